// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//
// Contents:
//   WORD_WIDTH   - width of one memory word and of the data buses
//   state_t      - responder FSM state encoding (IDLE / WAIT / RESP)
//   addr_is_bad  - error check for a byte address against the array size
package dmem_responder_pkg;

    localparam int WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_WAIT = 2'd1,
        STATE_RESP = 2'd2
    } state_t;

    // A request is in error when it is not word aligned or when any address
    // bit above the word-index field is set (it would otherwise alias into
    // the array).
    function automatic logic addr_is_bad(input logic [31:0] addr, input int addr_width);
        logic [31:0] high_bits;
        high_bits = addr >> (addr_width + 2);
        return (addr[1:0] != 2'b00) || (high_bits != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Word array behind the data-memory responder.
//
// Synchronous write, registered read, no reset (contents are undefined
// until written).
//
// Ports:
//   clk    - clock
//   we     - write enable for this edge
//   widx   - word index written when we is high
//   wdata  - word written when we is high
//   ridx   - word index read; rdata shows mem[ridx] one edge later
//   rdata  - registered read data
module dmem_responder_array
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   widx,
    input  logic [WORD_WIDTH-1:0]   wdata,
    input  logic [ADDR_WIDTH-1:0]   ridx,
    output logic [WORD_WIDTH-1:0]   rdata
);

    logic [WORD_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [WORD_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[widx] <= wdata;
        end
        rdata_q <= mem_q[ridx];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: slave end of the CPU load/store path.
//
// Accepts one word request over req_valid/req_ready, waits LATENCY cycles,
// then presents a response over resp_valid/resp_ready with backpressure.
//
// Ports:
//   clk         - clock, rising edge
//   reset       - asynchronous active-low reset
//   req_valid   - request present
//   req_ready   - responder can accept (IDLE only)
//   req_write   - 1 = store, 0 = load
//   req_addr    - byte address
//   req_wdata   - store data
//   resp_valid  - response present
//   resp_ready  - requester takes the response
//   resp_rdata  - load data; 0 for stores and errors
//   resp_err    - misaligned or out-of-range request
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    // With a single-cycle latency the access happens on the accept edge
    // itself, straight from the request inputs.
    localparam logic       DIRECT    = (LATENCY == 1);
    localparam logic [3:0] CNT_START = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic        load_ok_q, load_ok_d;

    logic        accept;
    logic        acc_now;
    logic        acc_write;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_err;

    logic                  arr_we;
    logic [ADDR_WIDTH-1:0] arr_ridx;
    logic [31:0]           arr_rdata;

    assign accept = req_valid && (state_q == STATE_IDLE);

    // Select which request fields drive the array access and when the access
    // edge occurs.
    always_comb begin
        acc_write = write_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_now   = (state_q == STATE_WAIT) && (cnt_q == 4'd1);
        if (DIRECT) begin
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_now   = accept;
        end
        acc_err = addr_is_bad(acc_addr, ADDR_WIDTH);
    end

    // The read port keeps re-reading the request's word from the accept
    // edge on. Nothing writes the array while a load is outstanding, so the
    // registered read data stays equal to the value captured at the access
    // edge for the whole response.
    assign arr_we   = acc_now && acc_write && !acc_err;
    assign arr_ridx = (state_q == STATE_IDLE) ? req_addr[ADDR_WIDTH+1:2]
                                              : addr_q[ADDR_WIDTH+1:2];

    dmem_responder_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .widx  (acc_addr[ADDR_WIDTH+1:2]),
        .wdata (acc_wdata),
        .ridx  (arr_ridx),
        .rdata (arr_rdata)
    );

    // Next-state logic: latch on accept, count down in WAIT, settle the
    // response status on the access edge, and release it on resp_ready.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        load_ok_d = load_ok_q;
        case (state_q)
            STATE_IDLE: begin
                if (accept) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (DIRECT) begin
                        state_d   = STATE_RESP;
                        err_d     = acc_err;
                        load_ok_d = !acc_write && !acc_err;
                    end else begin
                        cnt_d   = CNT_START;
                        state_d = STATE_WAIT;
                    end
                end
            end
            STATE_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (acc_now) begin
                    state_d   = STATE_RESP;
                    err_d     = acc_err;
                    load_ok_d = !acc_write && !acc_err;
                end
            end
            STATE_RESP: begin
                if (resp_ready) begin
                    state_d   = STATE_IDLE;
                    err_d     = 1'b0;
                    load_ok_d = 1'b0;
                end
            end
            default: begin
                state_d   = STATE_IDLE;
                err_d     = 1'b0;
                load_ok_d = 1'b0;
            end
        endcase
    end

    // State registers; reset drops any pending request or response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= STATE_IDLE;
            cnt_q     <= 4'd0;
            write_q   <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            err_q     <= 1'b0;
            load_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            load_ok_q <= load_ok_d;
        end
    end

    assign req_ready  = (state_q == STATE_IDLE);
    assign resp_valid = (state_q == STATE_RESP);
    assign resp_err   = err_q;
    assign resp_rdata = load_ok_q ? arr_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder.
//
// Two instances share the clock and reset: index 0 is built with LATENCY=4,
// index 1 with LATENCY=1; both use ADDR_WIDTH=10. A word-array model kept
// here predicts load data and error status from the address rules alone.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic reset;

    logic        reqValid  [2];
    logic        reqWrite  [2];
    logic [31:0] reqAddr   [2];
    logic [31:0] reqWdata  [2];
    logic        respReady [2];

    logic        reqReady0, respValid0, respErr0;
    logic [31:0] respRdata0;
    logic        reqReady1, respValid1, respErr1;
    logic [31:0] respRdata1;

    int checks     = 0;
    int failures   = 0;
    int cycleCount = 0;
    int lastAccept [2];

    logic [31:0] modelMem   [2][1024];
    bit          modelKnown [2][1024];

    // Free-running clock and cycle counter used for accept spacing.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycleCount <= cycleCount + 1;
    end

    dmem_responder #(
        .ADDR_WIDTH (10),
        .LATENCY    (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (reqValid[0]),
        .req_ready  (reqReady0),
        .req_write  (reqWrite[0]),
        .req_addr   (reqAddr[0]),
        .req_wdata  (reqWdata[0]),
        .resp_valid (respValid0),
        .resp_ready (respReady[0]),
        .resp_rdata (respRdata0),
        .resp_err   (respErr0)
    );

    dmem_responder #(
        .ADDR_WIDTH (10),
        .LATENCY    (1)
    ) dut1 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (reqValid[1]),
        .req_ready  (reqReady1),
        .req_write  (reqWrite[1]),
        .req_addr   (reqAddr[1]),
        .req_wdata  (reqWdata[1]),
        .resp_valid (respValid1),
        .resp_ready (respReady[1]),
        .resp_rdata (respRdata1),
        .resp_err   (respErr1)
    );

    function automatic int latOf(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] required);
        checks++;
        if (observed !== required) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%08h required=0x%08h", tag, observed, required);
        end
    endtask

    task automatic sampleOutputs(input int d, output logic rv, output logic rr,
                                 output logic [31:0] rd, output logic er);
        if (d == 0) begin
            rv = respValid0; rr = reqReady0; rd = respRdata0; er = respErr0;
        end else begin
            rv = respValid1; rr = reqReady1; rd = respRdata1; er = respErr1;
        end
    endtask

    // Reference behaviour: a word array of 1024 entries; any address that is
    // not a multiple of 4 or lies at or beyond 4 KiB is an error and touches
    // nothing.
    function automatic void predict(input int d, input logic wr, input logic [31:0] addr,
                                    input logic [31:0] wdata, output logic [31:0] expRdata,
                                    output logic expErr, output bit dataKnown);
        int idx;
        idx       = int'(addr / 4) % 1024;
        expErr    = (addr % 4 != 0) || (addr >= 32'd4096);
        expRdata  = 32'd0;
        dataKnown = 1'b1;
        if (!expErr) begin
            if (wr) begin
                modelMem[d][idx]   = wdata;
                modelKnown[d][idx] = 1'b1;
            end else begin
                expRdata  = modelMem[d][idx];
                dataKnown = modelKnown[d][idx];
            end
        end
    endfunction

    // Drive one request, scramble the request inputs while busy, then hold
    // the response for respDelay cycles before accepting it. Entered and
    // left just after a falling edge.
    task automatic applyStimulus(input int d, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int respDelay,
                                 input logic [31:0] expRdata, input logic expErr,
                                 input bit dataKnown, input string tag);
        logic rv, rr, er;
        logic [31:0] rd;
        int seen;
        seen = 0;
        sampleOutputs(d, rv, rr, rd, er);
        checkOutput({tag, "_ready_idle"}, 32'(rr), 32'd1);
        reqValid[d]  = 1'b1;
        reqWrite[d]  = wr;
        reqAddr[d]   = addr;
        reqWdata[d]  = wdata;
        respReady[d] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        lastAccept[d] = cycleCount;
        for (int n = 1; n <= 40 && seen == 0; n++) begin
            if (n > 1) @(negedge clk);
            sampleOutputs(d, rv, rr, rd, er);
            if (rv) begin
                seen = n;
            end else begin
                checkOutput({tag, "_busy_ready"}, 32'(rr), 32'd0);
                reqValid[d]  = 1'($urandom_range(0, 1));
                reqWrite[d]  = 1'($urandom_range(0, 1));
                reqAddr[d]   = $urandom;
                reqWdata[d]  = $urandom;
                respReady[d] = 1'($urandom_range(0, 1));
            end
        end
        reqValid[d]  = 1'b0;
        respReady[d] = 1'b0;
        if (seen == 0) begin
            checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        checkOutput({tag, "_latency"}, 32'(seen), 32'(latOf(d)));
        checkOutput({tag, "_err"}, 32'(er), 32'(expErr));
        if (dataKnown) checkOutput({tag, "_rdata"}, rd, expRdata);
        checkOutput({tag, "_resp_ready_low"}, 32'(rr), 32'd0);
        for (int k = 0; k < respDelay; k++) begin
            @(negedge clk);
            sampleOutputs(d, rv, rr, rd, er);
            checkOutput({tag, "_hold_valid"}, 32'(rv), 32'd1);
            checkOutput({tag, "_hold_err"}, 32'(er), 32'(expErr));
            if (dataKnown) checkOutput({tag, "_hold_rdata"}, rd, expRdata);
            checkOutput({tag, "_hold_ready"}, 32'(rr), 32'd0);
        end
        respReady[d] = 1'b1;
        @(negedge clk);
        respReady[d] = 1'b0;
        sampleOutputs(d, rv, rr, rd, er);
        checkOutput({tag, "_done_valid"}, 32'(rv), 32'd0);
        checkOutput({tag, "_done_ready"}, 32'(rr), 32'd1);
    endtask

    task automatic doTxn(input int d, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int respDelay, input string tag);
        logic [31:0] expRdata;
        logic expErr;
        bit dataKnown;
        predict(d, wr, addr, wdata, expRdata, expErr, dataKnown);
        applyStimulus(d, wr, addr, wdata, respDelay, expRdata, expErr, dataKnown, tag);
    endtask

    function automatic logic [31:0] randAddr();
        int unsigned sel;
        logic [31:0] a;
        sel = $urandom_range(0, 9);
        a   = 32'($urandom_range(0, 15)) << 2;
        if (sel == 8) a = a | 32'($urandom_range(1, 3));
        if (sel == 9) a = a | (32'($urandom_range(1, 1048575)) << 12);
        return a;
    endfunction

    task automatic checkIdle(input string tag);
        logic rv, rr, er;
        logic [31:0] rd;
        for (int d = 0; d < 2; d++) begin
            sampleOutputs(d, rv, rr, rd, er);
            checkOutput({tag, "_ready"}, 32'(rr), 32'd1);
            checkOutput({tag, "_valid"}, 32'(rv), 32'd0);
            checkOutput({tag, "_rdata"}, rd, 32'd0);
            checkOutput({tag, "_err"}, 32'(er), 32'd0);
        end
    endtask

    // Bound the whole run in case the design stops responding entirely.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized traffic on both instances.
    initial begin
        int a;
        for (int d = 0; d < 2; d++) begin
            reqValid[d]  = 1'b0;
            reqWrite[d]  = 1'b0;
            reqAddr[d]   = 32'd0;
            reqWdata[d]  = 32'd0;
            respReady[d] = 1'b0;
        end
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdle("in_reset");
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkIdle("post_reset");
        end

        $display("[TB] store/load with latency 4");
        doTxn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, "st10");
        doTxn(0, 1'b0, 32'h10, 32'h0, 0, "ld10");

        $display("[TB] backpressure");
        doTxn(0, 1'b0, 32'h10, 32'h0, 5, "bp");

        $display("[TB] error responses");
        doTxn(0, 1'b1, 32'h12, 32'h11111111, 0, "st_mis");
        doTxn(0, 1'b1, 32'h1010, 32'h55555555, 0, "st_oor");
        doTxn(0, 1'b0, 32'h10, 32'h0, 0, "ld10_after_err");
        doTxn(0, 1'b0, 32'h1000, 32'h0, 1, "ld_oor");

        $display("[TB] latency 1 back to back");
        doTxn(1, 1'b1, 32'h0, 32'h12345678, 0, "l1_st");
        a = lastAccept[1];
        doTxn(1, 1'b0, 32'h0, 32'h0, 0, "l1_ld");
        checkOutput("l1_spacing", 32'(lastAccept[1] - a), 32'd2);

        $display("[TB] reset during wait");
        doTxn(0, 1'b1, 32'h20, 32'h0, 0, "pre20");
        reqValid[0] = 1'b1;
        reqWrite[0] = 1'b1;
        reqAddr[0]  = 32'h20;
        reqWdata[0] = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        reqValid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("midreset_ready", 32'(reqReady0), 32'd1);
        checkOutput("midreset_valid", 32'(respValid0), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("midreset_no_stale", 32'(respValid0), 32'd0);
        end
        doTxn(0, 1'b0, 32'h20, 32'h0, 0, "ld20_after_reset");

        $display("[TB] randomized traffic");
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                doTxn(d, 1'b1, 32'(i) << 2, $urandom, 0, "rnd_init");
            end
            for (int i = 0; i < 30; i++) begin
                doTxn(d, 1'($urandom_range(0, 1)), randAddr(), $urandom,
                      int'($urandom_range(0, 3)), "rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
